// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle chunked add/sub with VNZC flags (ADC/SBC capable)
// Optional result saturation on overflow when CHUNKED_ADDER_SAT_EN is defined.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin_en,
  input  logic             cin,
  input  logic             sign,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             sign_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             busy_q;
  logic             done_q;
`ifdef CHUNKED_ADDER_SAT_EN
  logic             sub_q;
`endif

  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_d;
  logic             last;
  logic             cout;
  logic             carry_msb;
  logic             v_raw;

  assign result = result_q;
  assign flags  = flags_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Operands shift right each cycle so the active slice is always the low CHUNK bits;
  // the partial sum fills in from the top and is complete after the last slice.
  assign last  = (idx_q == IDXW'(NCHUNK - 1));
  assign slice = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign sum_d = (sum_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
  assign cout  = slice[CHUNK];

  // On the top slice, the carry into the MSB falls out of the MSB's own sum bit.
  assign carry_msb = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice[CHUNK-1];
  assign v_raw     = sign_q & (carry_msb ^ cout);

  always_comb begin
    flags_d    = 4'b0000;
    flags_d[3] = cout;
    flags_d[2] = (sum_d == '0);
    flags_d[1] = sign_q & sum_d[WIDTH-1];
    flags_d[0] = v_raw;
    result_d   = sum_d;
`ifdef CHUNKED_ADDER_SAT_EN
    if (sign_q && v_raw) begin
      result_d = a_q[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else if (!sign_q && !sub_q && cout) begin
      result_d = '1;
    end else if (!sign_q && sub_q && !cout) begin
      result_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CHUNKED_ADDER_SAT_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            sign_q  <= sign;
            carry_q <= cin_en ? cin : sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef CHUNKED_ADDER_SAT_EN
            sub_q   <= sub;
`endif
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          sum_q   <= sum_d;
          carry_q <= cout;
          idx_q   <= idx_q + IDXW'(1);
          if (last) begin
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            idx_q    <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - self-checking bench for chunked_adder (WIDTH=32, CHUNK=8)
module tb_chunked_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin_en;
    logic        cin;
    logic        sign;
    logic [31:0] er;
    logic [3:0]  ef;
  } vec_t;

`ifdef CHUNKED_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk, reset, start, sub, cin_en, cin, sign, busy, done;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] exp_q[$];
  vec_t        vt[13];

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sub(sub),
    .cin_en(cin_en), .cin(cin), .sign(sign), .result(result), .flags(flags),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic [31:0] av, bv, input logic s, ce, ci, sg,
                               input logic [31:0] er, input logic [3:0] ef);
    vec_t v;
    v.a = av; v.b = bv; v.sub = s; v.cin_en = ce; v.cin = ci; v.sign = sg;
    v.er = er; v.ef = ef;
    return v;
  endfunction

  // Whole-word reference: {C,Z,N,V,result}
  function automatic logic [35:0] model(input vec_t v);
    logic [31:0] bb, r;
    logic [32:0] s;
    logic        c, ov;
    bb = v.sub ? ~v.b : v.b;
    s  = {1'b0, v.a} + {1'b0, bb} + {32'd0, (v.cin_en ? v.cin : v.sub)};
    r  = s[31:0];
    c  = s[32];
    ov = v.sign && (v.a[31] == bb[31]) && (r[31] != v.a[31]);
    model = {c, (r == 32'd0), v.sign & r[31], ov, r};
    if (SAT) begin
      if (ov) model[31:0] = v.a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else if (!v.sign && !v.sub && c) model[31:0] = 32'hFFFF_FFFF;
      else if (!v.sign && v.sub && !c) model[31:0] = 32'h0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic start_only(input vec_t v);
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; cin_en = v.cin_en; cin = v.cin; sign = v.sign;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(output int cnt, output bit got, output bit busy_ok);
    cnt = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic pop_cmp(input string name);
    logic [35:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
    chk({name, "_result"}, result, e[31:0]);
    chk({name, "_flags"}, {28'd0, flags}, {28'd0, e[35:32]});
  endtask

  task automatic do_op(input vec_t v, input logic [35:0] e, input string name);
    int cnt; bit got, bok;
    start_only(v);
    exp_q.push_back(e);
    a = $urandom; b = $urandom; sub = ~sub; sign = ~sign; cin = ~cin;
    wait_done(cnt, got, bok);
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({name, "_latency"}, cnt, 32'd4);
    chk({name, "_busy_run"}, {31'd0, bok}, 32'd1);
    chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
    pop_cmp(name);
  endtask

  initial begin
    int cnt, dcount; bit got, bok;
    vec_t rv;
    logic [31:0] held;

    vt[0]  = mkv(32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, SAT ? 32'hFFFF_FFFF : 32'h0, 4'b1100);
    vt[1]  = mkv(32'h7FFF_FFFF, 32'd1, 0, 0, 0, 1, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 4'b0011);
    vt[2]  = mkv(32'd5, 32'd7, 1, 0, 0, 1, 32'hFFFF_FFFE, 4'b0010);
    vt[3]  = mkv(32'd7, 32'd5, 1, 0, 0, 0, 32'd2, 4'b1000);
    vt[4]  = mkv(32'hFFFF_FFFF, 32'd0, 0, 1, 1, 0, SAT ? 32'hFFFF_FFFF : 32'h0, 4'b1100);
    vt[5]  = mkv(32'd1, 32'd2, 0, 1, 1, 0, 32'd4, 4'b0000);
    vt[6]  = mkv(32'd5, 32'd7, 1, 0, 0, 0, SAT ? 32'h0 : 32'hFFFF_FFFE, 4'b0000);
    vt[7]  = mkv(32'h8000_0000, 32'h8000_0000, 0, 0, 0, 1, SAT ? 32'h8000_0000 : 32'h0, 4'b1101);
    vt[8]  = mkv(32'd7, 32'd5, 1, 1, 0, 0, 32'd1, 4'b1000);
    vt[9]  = mkv(32'd3, 32'd4, 0, 1, 0, 0, 32'd7, 4'b0000);
    vt[10] = mkv(32'h0000_00FF, 32'd1, 0, 0, 0, 0, 32'h0000_0100, 4'b0000);
    vt[11] = mkv(32'h1234_5678, 32'h1111_1111, 0, 0, 0, 1, 32'h2345_6789, 4'b0000);
    vt[12] = mkv(32'h8000_0000, 32'd1, 1, 0, 0, 1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 4'b1001);

    reset = 1'b1; start = 1'b0; a = '0; b = '0; sub = 0; cin_en = 0; cin = 0; sign = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op(vt[i], {vt[i].ef, vt[i].er}, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv = mkv($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 32'd0, 4'd0);
      do_op(rv, model(rv), $sformatf("rand%0d", i));
    end

    held = result;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("result_held", result, held);

    // A start arriving mid-operation must be dropped.
    start_only(vt[11]);
    exp_q.push_back({vt[11].ef, vt[11].er});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    a = 32'd0; b = 32'd0; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cnt, got, bok);
    chk("ign_latency", cnt, 32'd1);
    pop_cmp("ign");

    // Back-to-back: start raised while done is high.
    a = vt[10].a; b = vt[10].b; sub = vt[10].sub; cin_en = vt[10].cin_en;
    cin = vt[10].cin; sign = vt[10].sign; start = 1'b1;
    exp_q.push_back({vt[10].ef, vt[10].er});
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(cnt, got, bok);
    chk("b2b_latency", cnt, 32'd4);
    pop_cmp("b2b");
    dcount = 0;
    repeat (6) begin @(posedge clk); #1; if (done) dcount++; end
    chk("no_extra_done", dcount, 32'd0);

    // Asynchronous reset mid-operation aborts without a done pulse.
    start_only(vt[1]);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", {28'd0, flags}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;
    dcount = 0;
    repeat (8) begin @(posedge clk); #1; if (done) dcount++; end
    chk("midrst_no_done", dcount, 32'd0);
    do_op(vt[3], {vt[3].ef, vt[3].er}, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
Parametrised multi-cycle adder/subtractor with a VNZC flag register. It processes WIDTH-bit operands CHUNK bits per clock, LSB slice first, and supports add, subtract and carry-chained add/subtract (ADC/SBC). It is the datapath arithmetic unit for the ALU, with a start/busy/done handshake toward the control unit. Flag bit order is [0]=V, [1]=N, [2]=Z, [3]=C.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of CHUNK
CHUNK, 8, bits processed per clock
NCHUNK (localparam), WIDTH/CHUNK, cycles per operation

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  1 = A - B (A + ~B + carry0), 0 = A + B
cin_en  input  1  1 = use cin as carry0 (ADC/SBC)
cin  input  1  external carry-in (normally the previous C flag)
sign  input  1  1 = signed interpretation, 0 = unsigned
result  output  WIDTH  registered sum/difference, held until the next completion
flags  output  4  registered {C,Z,N,V}, held until the next completion
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result and flags are updated

Behaviour:
- Reset (asynchronous, any time): state=IDLE, result=0, flags=4'b0000, busy=0, done=0, chunk index=0, internal carry=0. A reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE and RUN.
- IDLE, start=1 at edge k:
  - latch a, sign, sub, and b (stored inverted when sub=1)
  - carry0 = cin_en ? cin : sub
  - idx=0, go to RUN, busy=1 from edge k
- RUN, edge k+1+i (i = 0..NCHUNK-1):
  - slice i = a_slice + b_slice + carry (CHUNK+1 bits)
  - store slice i; carry <= bit CHUNK; idx++
  - keep the carry into the MSB of the top slice for the V computation
- Last slice (edge k+NCHUNK):
  - write result
  - compute flags
  - state -> IDLE, busy=0, done=1 for exactly one cycle
- Latency: done is high in the cycle following edge k+NCHUNK (NCHUNK clocks after start is accepted).
- Flags when sign=1:
  - C = final carry-out
  - N = result[WIDTH-1]
  - Z = (result==0)
  - V = carry into MSB XOR carry out of MSB
- Flags when sign=0:
  - C = final carry-out
  - Z = (result==0)
  - N = 0, V = 0
- Subtract carry is ARM-style: C=1 means no borrow.
- start while busy is ignored. Input changes during RUN have no effect, because operands are latched.
- start may be accepted in the same cycle done is high (back-to-back operation).
- cin_en=0 with sub=0 gives carry0=0. cin_en=1 with sub=1 gives carry0=cin (SBC).
- result and flags change only on the completion edge or on reset.

Optional Feature:
CHUNKED_ADDER_SAT_EN — when defined, the result saturates on overflow:
- sign=1 and V=1: result clamps to the signed max (0x7FF..F) or min (0x800..0), chosen by the sign of A.
- sign=0, add with C=1: result clamps to all ones.
- sign=0, sub with C=0: result clamps to 0.
- flags always report the raw (unsaturated) computation.
When undefined, the result wraps modulo 2^WIDTH; no saturation logic exists.

Test Plan:
- WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=1, sub=0, sign=0 -> result=0x00000000, flags=4'b1100 (C,Z); done 4 clocks after start, busy high for those 4 cycles.
- sign=1, a=0x7FFFFFFF, b=1, add -> result=0x80000000, flags=4'b0011 (N,V); with CHUNKED_ADDER_SAT_EN: result=0x7FFFFFFF, flags=4'b0011.
- sign=1, sub, a=5, b=7 -> result=0xFFFFFFFE, flags=4'b0010 (N, C=0 borrow); sign=0, sub, a=7, b=5 -> result=2, flags=4'b1000.
- ADC chain: a=0xFFFFFFFF, b=0, cin_en=1, cin=1, sign=0 -> result=0, flags=4'b1100; then a=1, b=2, cin_en=1, cin=1 -> result=4, flags=4'b0000.
- Second start pulsed 2 cycles into an operation -> ignored, exactly one done; new start in the done cycle -> accepted, next done 4 clocks later.
- reset asserted 2 cycles into an operation -> result=0, flags=0, busy=0 immediately; no done pulse; the next start completes normally.
